// File: rtl/button_toggle_bank_pkg.sv
// Shared constants and the per-channel output-level rule for the button bank.
package button_toggle_bank_pkg;

  localparam logic MODE_TOGGLE    = 1'b0;
  localparam logic MODE_MOMENTARY = 1'b1;

  // Next output level of one channel: follow the debounced level, or toggle on a press with clear winning.
  function automatic logic next_level(
    input logic mode,
    input logic cur,
    input logic stable,
    input logic pulse,
    input logic clr
  );
    logic nxt;
    if (mode == MODE_MOMENTARY) begin
      nxt = stable;
    end else if (clr) begin
      nxt = 1'b0;
    end else begin
      nxt = cur ^ pulse;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/button_toggle_bank_debounce.sv
// One button channel: 2-flop synchroniser, persistence counter, accepted level and rising-edge pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic stable,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync;
  logic             stable_prev;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta   <= 1'b0;
      sync        <= 1'b0;
      stable      <= 1'b0;
      stable_prev <= 1'b0;
      cnt         <= '0;
    end else begin
      sync_meta   <= btn_in;
      sync        <= sync_meta;
      stable_prev <= stable;
      // The counter measures how long sync has disagreed with stable; any agreement restarts it.
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Both terms are registers, so the pulse cannot glitch.
  assign press_pulse = stable & ~stable_prev;

endmodule

// File: rtl/button_toggle_bank.sv
// Bank of debounced buttons with per-channel press pulses and a toggle/momentary output level.
module button_toggle_bank
  import button_toggle_bank_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             mode,
  input  logic [N_BTN-1:0] clear,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] state
);

  logic [N_BTN-1:0] stable;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .btn_in     (btn_in[g]),
      .stable     (stable[g]),
      .press_pulse(press_pulse[g])
    );
  end

  // Switching back to toggle mode keeps whatever level momentary mode left behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state[i] <= next_level(mode, state[i], stable[i], press_pulse[i], clear[i]);
      end
    end
  end

endmodule

// File: tb/tb_button_toggle_bank.sv
// Randomised and directed stimulus for button_toggle_bank, scored against a sample-history model.
module tb_button_toggle_bank;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] btn_in;
  logic         mode;
  logic [N-1:0] clear;
  logic [N-1:0] press_pulse;
  logic [N-1:0] state;

  button_toggle_bank #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .mode       (mode),
    .clear      (clear),
    .press_pulse(press_pulse),
    .state      (state)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // scoreboard: {press_pulse, state} expected after each rising edge
  logic [2*N-1:0] exp_q[$];

  // Reference model: a channel's accepted level flips once the raw samples seen
  // two to D+1 edges ago all disagree with it; history before a reset reads as 0.
  bit           hist[N][$];
  logic [N-1:0] m_stable = '0;
  logic [N-1:0] m_prev   = '0;
  logic [N-1:0] m_state  = '0;

  task automatic model_step();
    logic [N-1:0] old_pulse;
    logic [N-1:0] nxt_stable;
    bit           flip;
    old_pulse  = m_stable & ~m_prev;
    nxt_stable = m_stable;
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        hist[i].delete();
        for (int k = 0; k < D + 2; k++) hist[i].push_back(1'b0);
      end else begin
        hist[i].push_back(btn_in[i]);
        void'(hist[i].pop_front());
        flip = 1'b1;
        for (int k = 0; k < D; k++) begin
          if (hist[i][k] == m_stable[i]) flip = 1'b0;
        end
        if (flip) nxt_stable[i] = ~m_stable[i];
      end
    end
    if (reset) begin
      m_stable = '0;
      m_prev   = '0;
      m_state  = '0;
    end else begin
      if (mode) m_state = m_stable;
      else      m_state = (m_state ^ old_pulse) & ~clear;
      m_prev   = m_stable;
      m_stable = nxt_stable;
    end
    exp_q.push_back({m_stable & ~m_prev, m_state});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  // monitor: every cycle the DUT presents a pulse vector and a level vector
  initial begin
    logic [2*N-1:0] exp;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        checks++;
        if ({press_pulse, state} !== exp) begin
          failures++;
          $display("FAIL outputs cyc=%0d pulse=%b state=%b expected pulse=%b state=%b",
                   cyc, press_pulse, state, exp[2*N-1:N], exp[N-1:0]);
        end
      end
    end
  end

  // driver tasks: inputs change on the falling edge
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int ch, input int high, input int low);
    btn_in[ch] = 1'b1;
    wait_cycles(high);
    btn_in[ch] = 1'b0;
    wait_cycles(low);
  endtask

  task automatic random_phase(input int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) btn_in[i] = ~btn_in[i];
        clear[i] = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      reset = ($urandom_range(0, 199) == 0);
      wait_cycles(1);
    end
    reset = 1'b0;
    clear = '0;
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = '0;
    mode   = 1'b0;
    clear  = '0;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(20);

    // clean presses in toggle mode
    press(0, 20, 20);
    press(0, 20, 20);

    // bounce shorter than the debounce window, then a pulse exactly as long
    for (int k = 0; k < 2; k++) press(1, 2, 2);
    wait_cycles(10);
    press(1, D, 12);

    // momentary mode
    mode = 1'b1;
    press(2, 10, 15);
    mode = 1'b0;
    wait_cycles(2);

    // clear against a coincident press, then simultaneous presses
    press(0, 10, 10);
    clear[0] = 1'b1;
    press(0, 10, 2);
    clear[0] = 1'b0;
    wait_cycles(8);
    btn_in[2] = 1'b1;
    btn_in[3] = 1'b1;
    wait_cycles(12);
    btn_in = '0;
    wait_cycles(12);

    // reset in the middle of a debounce run
    btn_in[3] = 1'b1;
    wait_cycles(5);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(15);
    btn_in[3] = 1'b0;
    wait_cycles(12);

    random_phase(1500);
    btn_in = '0;
    wait_cycles(12);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() > 1) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain pending=%0d expected at most 1", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
